// File: rtl/uc_io_hs_pkg.sv
// uc_io_pkg: state encodings, control-word constants and opcode fields for
// the Maquina Sencilla control unit with handshaked IN/OUT.
//
// Control word layout (12 bits):
//   [11]   ld_pc    load / increment program counter
//   [10]   ld_ir    load instruction register
//   [9]    we_mem   memory write enable
//   [8]    ld_a     load operand register A (source)
//   [7]    ld_b     load operand register B (destination)
//   [6]    ld_fz    load zero flag
//   [5:4]  alu_op   00 add, 01 sub/compare, 10 pass A
//   [3:2]  addr_sel 00 PC, 01 source field, 10 destination field
//   [1]    ld_out   load output data register
//   [0]    in_sel   memory write data comes from the input device
package uc_io_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        RD_SRC   = 4'd2,
        RD_DST   = 4'd6,
        WR_ALU   = 4'd7,
        WR_CMP   = 4'd9,
        WR_MOV   = 4'd10,
        BRANCH   = 4'd11,
        IN_WAIT  = 4'd12,
        OUT_WAIT = 4'd13,
        IN_WR    = 4'd14,
        OUT_RD   = 4'd15
    } state_e;

    localparam logic [11:0] CW_FETCH    = 12'hC00;
    localparam logic [11:0] CW_DECODE   = 12'h004;
    localparam logic [11:0] CW_RD_SRC   = 12'h104;
    localparam logic [11:0] CW_RD_DST   = 12'h088;
    localparam logic [11:0] CW_WR_ALU   = 12'h248;
    localparam logic [11:0] CW_WR_CMP   = 12'h058;
    localparam logic [11:0] CW_WR_MOV   = 12'h228;
    localparam logic [11:0] CW_BRANCH   = 12'hC04;
    localparam logic [11:0] CW_IN_WAIT  = 12'h000;
    localparam logic [11:0] CW_IN_WR    = 12'h209;
    localparam logic [11:0] CW_OUT_RD   = 12'h006;
    localparam logic [11:0] CW_OUT_WAIT = 12'h000;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_MOV  = 2'b10;
    localparam logic [1:0] OP_EXT  = 2'b11;
    localparam logic [1:0] EXT_IN  = 2'b10;
    localparam logic [1:0] EXT_OUT = 2'b11;

    // True in the two states where the unit waits on an I/O device.
    function automatic logic is_wait(input logic [3:0] st);
        return (st == IN_WAIT) || (st == OUT_WAIT);
    endfunction

endpackage

// File: rtl/uc_io_hs_if.sv
// uc_io_hs_if: instruction fields, flags, I/O handshakes and control word
// between the control unit (master) and the datapath / devices (slave).
//
// Handshake semantics: a transfer happens on the rising edge where valid and
// ready are both 1. The unit raises in_ready in IN_WAIT and out_valid in
// OUT_WAIT and keeps it up until the transfer (or a reset / timeout); the
// device side may assert in_valid / out_ready at any time, they are only
// looked at while the unit is in the matching wait state.
interface uc_io_hs_if #(
    parameter int PORT_W = 2
);
    logic [1:0]        op;
    logic [1:0]        ext;
    logic              fz;
    logic [PORT_W-1:0] io_addr;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [PORT_W-1:0] io_port;
    logic [11:0]       cw;

    modport master (
        input  op, ext, fz, io_addr, in_valid, out_ready,
        output in_ready, out_valid, io_port, cw
    );

    modport slave (
        output op, ext, fz, io_addr, in_valid, out_ready,
        input  in_ready, out_valid, io_port, cw
    );
endinterface

// File: rtl/uc_io_hs_wait_cnt.sv
// uc_io_hs_wait_cnt: counts cycles spent in an I/O wait state and flags the
// cycle in which the TIMEOUT_CYC-th wait cycle is being spent. The count is
// held at zero outside the wait states, so it is clear on every entry.
module uc_io_hs_wait_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_wait,
    output logic o_expired
);
    localparam int CLOG = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = (CLOG > 8) ? CLOG : 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count completed wait cycles; saturate at the last one.
    always_ff @(posedge clk) begin
        if (rst || !i_wait) begin
            r_cnt <= '0;
        end else if (r_cnt != LAST) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt counts earlier wait cycles, so r_cnt == LAST is the final one.
    assign o_expired = i_wait && (r_cnt == LAST);
endmodule

// File: rtl/uc_io_hs.sv
// uc_io_hs: Moore control unit for the Maquina Sencilla datapath with
// valid/ready IN/OUT, latched I/O port address and synchronous reset.
// Optional macro UC_IO_TIMEOUT_EN bounds the IN/OUT waits to TIMEOUT_CYC
// cycles and adds the sticky io_err output.
module uc_io_hs
    import uc_io_pkg::*;
#(
    parameter int PORT_W      = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    uc_io_hs_if.master    bus,
    output logic [3:0]    state_o
`ifdef UC_IO_TIMEOUT_EN
    , output logic        io_err
`endif
);
    state_e            r_state;
    state_e            w_next;
    logic [PORT_W-1:0] r_io_port;
    logic [11:0]       w_cw;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_timeout;

    // Transfers only count in the matching wait state.
    assign w_in_xfer  = (r_state == IN_WAIT)  && bus.in_valid;
    assign w_out_xfer = (r_state == OUT_WAIT) && bus.out_ready;

`ifdef UC_IO_TIMEOUT_EN
    logic w_expired;
    logic r_io_err;

    uc_io_hs_wait_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_wait    (is_wait(r_state)),
        .o_expired (w_expired)
    );

    // A handshake on the expiry edge completes normally.
    assign w_timeout = w_expired && !w_in_xfer && !w_out_xfer;

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_err <= 1'b0;
        end else if (w_timeout) begin
            r_io_err <= 1'b1;
        end
    end

    assign io_err = r_io_err;
`else
    assign w_timeout = 1'b0;
`endif

    // State register; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; unknown encodings fall back to FETCH.
    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                if (bus.op != OP_EXT) begin
                    w_next = RD_SRC;
                end else if (!bus.ext[1]) begin
                    w_next = bus.fz ? BRANCH : FETCH;
                end else if (bus.ext == EXT_IN) begin
                    w_next = IN_WAIT;
                end else begin
                    w_next = OUT_RD;
                end
            end
            RD_SRC:   w_next = bus.op[1] ? WR_MOV : RD_DST;
            RD_DST:   w_next = bus.op[0] ? WR_CMP : WR_ALU;
            WR_ALU:   w_next = FETCH;
            WR_CMP:   w_next = FETCH;
            WR_MOV:   w_next = FETCH;
            BRANCH:   w_next = DECODE;
            IN_WAIT: begin
                if (w_in_xfer) begin
                    w_next = IN_WR;
                end else if (w_timeout) begin
                    w_next = FETCH;
                end else begin
                    w_next = IN_WAIT;
                end
            end
            IN_WR:    w_next = FETCH;
            OUT_RD:   w_next = OUT_WAIT;
            OUT_WAIT: begin
                if (w_out_xfer || w_timeout) begin
                    w_next = FETCH;
                end else begin
                    w_next = OUT_WAIT;
                end
            end
            default:  w_next = FETCH;
        endcase
    end

    // Moore outputs: functions of the state register alone.
    always_comb begin
        w_cw        = CW_FETCH;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            FETCH:    w_cw = CW_FETCH;
            DECODE:   w_cw = CW_DECODE;
            RD_SRC:   w_cw = CW_RD_SRC;
            RD_DST:   w_cw = CW_RD_DST;
            WR_ALU:   w_cw = CW_WR_ALU;
            WR_CMP:   w_cw = CW_WR_CMP;
            WR_MOV:   w_cw = CW_WR_MOV;
            BRANCH:   w_cw = CW_BRANCH;
            IN_WAIT: begin
                w_cw       = CW_IN_WAIT;
                w_in_ready = 1'b1;
            end
            IN_WR:    w_cw = CW_IN_WR;
            OUT_RD:   w_cw = CW_OUT_RD;
            OUT_WAIT: begin
                w_cw        = CW_OUT_WAIT;
                w_out_valid = 1'b1;
            end
            default:  w_cw = CW_FETCH;
        endcase
    end

    // Port address is captured only while decoding an IN or OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_port <= '0;
        end else if ((r_state == DECODE) && (bus.op == OP_EXT) && bus.ext[1]) begin
            r_io_port <= bus.io_addr;
        end
    end

    assign bus.cw        = w_cw;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.io_port   = r_io_port;
    assign state_o       = r_state;
endmodule

// File: tb/tb_uc_io_hs.sv
// tb_uc_io_hs: directed bench for uc_io_hs. The driver pushes the expected
// per-cycle outputs into exp_q; a monitor on the falling edge pops and compares.
// Build with UC_IO_TIMEOUT_EN to also exercise the timeout (TIMEOUT_CYC=8).
module tb_uc_io_hs;
    localparam int W = 21;   // {state[4], cw[12], in_ready, out_valid, port[2], err}

    logic       clk;
    logic       rst;
    logic [3:0] state_o;
    logic       dut_err;

    uc_io_hs_if #(.PORT_W(2)) bus ();

`ifdef UC_IO_TIMEOUT_EN
    uc_io_hs #(.PORT_W(2), .TIMEOUT_CYC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o),
        .io_err  (dut_err)
    );
`else
    uc_io_hs #(.PORT_W(2), .TIMEOUT_CYC(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );
    assign dut_err = 1'b0;
`endif

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    logic [1:0] exp_port = 2'd0;
    logic       exp_err  = 1'b0;

    // Hand-written control words per state encoding.
    function automatic logic [11:0] cw_of(input logic [3:0] st);
        case (st)
            4'd0:    return 12'hC00;
            4'd1:    return 12'h004;
            4'd2:    return 12'h104;
            4'd6:    return 12'h088;
            4'd7:    return 12'h248;
            4'd9:    return 12'h058;
            4'd10:   return 12'h228;
            4'd11:   return 12'hC04;
            4'd14:   return 12'h209;
            4'd15:   return 12'h006;
            default: return 12'h000;   // 12, 13: datapath holds
        endcase
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Wait for the next active edge, then record what the unit must show now.
    task automatic step(input logic [3:0] st);
        @(posedge clk);
        #1;
        exp_q.push_back({st, cw_of(st), st == 4'd12, st == 4'd13, exp_port, exp_err});
    endtask

    task automatic steps(input logic [3:0] st, input int n);
        for (int i = 0; i < n; i++) step(st);
    endtask

    // Monitor: compare every recorded cycle mid-period.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",     {8'd0, state_o},       {8'd0, e[20:17]});
            check("cw",        bus.cw,                e[16:5]);
            check("in_ready",  {11'd0, bus.in_ready}, {11'd0, e[4]});
            check("out_valid", {11'd0, bus.out_valid},{11'd0, e[3]});
            check("io_port",   {10'd0, bus.io_port},  {10'd0, e[2:1]});
`ifdef UC_IO_TIMEOUT_EN
            check("io_err",    {11'd0, dut_err},      {11'd0, e[0]});
`endif
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.op = 2'b00; bus.ext = 2'b00; bus.fz = 1'b0; bus.io_addr = 2'd0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back({4'd0, cw_of(4'd0), 1'b0, 1'b0, 2'd0, 1'b0});
        rst = 1'b0;

        // ADD: 0,1,2,6,7,0
        step(1); step(2); step(6); step(7); step(0);
        // CMP: 0,1,2,6,9,0
        bus.op = 2'b01;
        step(1); step(2); step(6); step(9); step(0);
        // MOV: 0,1,2,10,0
        bus.op = 2'b10;
        step(1); step(2); step(10); step(0);

        // BEQ taken then not taken; io_addr must not be captured
        bus.op = 2'b11; bus.ext = 2'b00; bus.fz = 1'b1; bus.io_addr = 2'd2;
        step(1); step(11);
        bus.fz = 1'b0;
        step(1); step(0);
        step(1); step(0);

        // IN on port 3, in_valid arrives in the 5th wait cycle
        bus.ext = 2'b10; bus.io_addr = 2'd3;
        step(1);
        exp_port = 2'd3;
        steps(12, 5);
        bus.in_valid = 1'b1;
        step(14);
        bus.in_valid = 1'b0;
        step(0);

        // OUT on port 1, out_ready low for 3 wait cycles
        bus.ext = 2'b11; bus.io_addr = 2'd1;
        step(1);
        exp_port = 2'd1;
        step(15);
        steps(13, 4);
        bus.out_ready = 1'b1;
        step(0);
        bus.out_ready = 1'b0;

        // OUT on port 2 aborted by reset mid-wait
        bus.io_addr = 2'd2;
        step(1);
        exp_port = 2'd2;
        step(15); step(13); step(13);
        rst = 1'b1;
        exp_port = 2'd0;
        step(0);
        rst = 1'b0;
        bus.op = 2'b00;
        step(1); step(2); step(6); step(7); step(0);

`ifdef UC_IO_TIMEOUT_EN
        // IN with no device: abandon after 8 wait cycles, set io_err
        bus.op = 2'b11; bus.ext = 2'b10; bus.io_addr = 2'd3;
        step(1);
        exp_port = 2'd3;
        steps(12, 8);
        exp_err = 1'b1;
        step(0);
        step(1);              // FETCH -> DECODE of the same IN again
        rst = 1'b1;
        exp_err = 1'b0; exp_port = 2'd0;
        step(0);
        rst = 1'b0;

        // in_valid on the timeout edge: handshake wins
        step(1);
        exp_port = 2'd3;
        steps(12, 8);
        bus.in_valid = 1'b1;
        step(14);
        bus.in_valid = 1'b0;
        step(0);
`endif

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
